serpent_roundkey_gen: RTL and testbench

- Downstream consumer of the prekey shift register in the Serpent key schedule.
- Samples the 128-bit oldest-four-prekeys window (pre_roundKeys) at the cycles where it holds an aligned group {w4i+3, w4i+2, w4i+1, w4i}.
- Applies the bitsliced Serpent S-box S((3-i) mod 8) to each group, giving round keys K0..K32.
- Streams each key out with a valid pulse and stores it in a 33-entry key file that the datapath reads by round index.

---
 rtl/serpent_pkg.sv | 40 ++++
 rtl/serpent_sbox_slice.sv | 25 ++
 rtl/serpent_roundkey_gen.sv | 153 +++++++++++++++
 tb/tb_serpent_roundkey_gen.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serpent_pkg.sv
`timescale 1ns/1ps
// Serpent constants shared by the key schedule and the cipher datapath:
// S-boxes S0..S7, key-schedule sizes and the round-key generator states.
package serpent_pkg;

  localparam int          NUM_ROUND_KEYS = 33;
  localparam logic [31:0] PHI            = 32'h9E3779B9;

  // SBOX[b][x] is Serpent S-box Sb applied to nibble x.
  localparam logic [3:0] SBOX [8][16] = '{
    '{4'h3, 4'h8, 4'hF, 4'h1, 4'hA, 4'h6, 4'h5, 4'hB,
      4'hE, 4'hD, 4'h4, 4'h2, 4'h7, 4'h0, 4'h9, 4'hC},
    '{4'hF, 4'hC, 4'h2, 4'h7, 4'h9, 4'h0, 4'h5, 4'hA,
      4'h1, 4'hB, 4'hE, 4'h8, 4'h6, 4'hD, 4'h3, 4'h4},
    '{4'h8, 4'h6, 4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hF,
      4'hD, 4'h1, 4'hE, 4'h4, 4'h0, 4'hB, 4'h5, 4'h2},
    '{4'h0, 4'hF, 4'hB, 4'h8, 4'hC, 4'h9, 4'h6, 4'h3,
      4'hD, 4'h1, 4'h2, 4'h4, 4'hA, 4'h7, 4'h5, 4'hE},
    '{4'h1, 4'hF, 4'h8, 4'h3, 4'hC, 4'h0, 4'hB, 4'h6,
      4'h2, 4'h5, 4'h4, 4'hA, 4'h9, 4'hE, 4'h7, 4'hD},
    '{4'hF, 4'h5, 4'h2, 4'hB, 4'h4, 4'hA, 4'h9, 4'hC,
      4'h0, 4'h3, 4'hE, 4'h8, 4'hD, 4'h6, 4'h7, 4'h1},
    '{4'h7, 4'h2, 4'hC, 4'h5, 4'h8, 4'h4, 4'h6, 4'hB,
      4'hE, 4'h9, 4'h1, 4'hF, 4'hD, 4'h3, 4'hA, 4'h0},
    '{4'h1, 4'hD, 4'hF, 4'h0, 4'hE, 4'h8, 4'h2, 4'hB,
      4'h7, 4'h4, 4'hC, 4'hA, 4'h9, 4'h3, 4'h5, 4'h6}
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GEN  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [3:0] nib);
    return SBOX[box][nib];
  endfunction

endpackage

// File: rtl/serpent_sbox_slice.sv
`timescale 1ns/1ps
// Bitsliced Serpent S-box layer: bit j of the four 32-bit words forms one nibble
// (word 0 is the LSB), and output bit k of that nibble lands in word k, bit j.
module serpent_sbox_slice
  import serpent_pkg::*;
(
  input  logic [127:0] group_in,
  input  logic [2:0]   box_sel,
  output logic [127:0] key_out
);

  for (genvar j = 0; j < 32; j++) begin : g_bit
    logic [3:0] nib;
    logic [3:0] sub;

    assign nib = {group_in[96+j], group_in[64+j], group_in[32+j], group_in[j]};
    assign sub = sbox_lookup(box_sel, nib);

    assign key_out[j]      = sub[0];
    assign key_out[32+j]   = sub[1];
    assign key_out[64+j]   = sub[2];
    assign key_out[96+j]   = sub[3];
  end

endmodule

// File: rtl/serpent_roundkey_gen.sv
`timescale 1ns/1ps
// Serpent round-key generator: samples aligned prekey groups, S-boxes them into
// K0..K32, streams each key and keeps it in a key file readable by round index.
module serpent_roundkey_gen
  import serpent_pkg::*;
#(
  parameter int NUM_KEYS       = NUM_ROUND_KEYS,
  parameter int CAPTURE_OFFSET = 8,
  parameter int KEY_W          = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sched_start,
  input  logic [KEY_W-1:0] pre_roundKeys,
  output logic             rk_valid,
  output logic [KEY_W-1:0] rk_data,
  output logic [5:0]       rk_num,
  input  logic [5:0]       rk_idx,
  output logic [KEY_W-1:0] rk_out,
  output logic             rk_out_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [7:0] OFFSET   = 8'(CAPTURE_OFFSET);
  localparam logic [5:0] NUM_K6   = 6'(NUM_KEYS);
  localparam logic [5:0] LAST_GRP = 6'(NUM_KEYS - 1);

  state_t           state_q, state_d;
  logic [7:0]       cyc_q, cyc_d;
  logic [5:0]       keys_written_q, keys_written_d;
  logic             rk_valid_q, rk_valid_d;
  logic [KEY_W-1:0] rk_data_q, rk_data_d;
  logic [5:0]       rk_num_q, rk_num_d;
  logic [KEY_W-1:0] rk_out_q, rk_out_d;
  logic             rk_out_valid_q, rk_out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [KEY_W-1:0] key_file [NUM_KEYS];

  logic [7:0]       cyc_rel;
  logic [5:0]       grp;
  logic [2:0]       box_sel;
  logic             capture_hit;
  logic [KEY_W-1:0] slice_key;

  // Group g sits in the window every fourth cycle starting at CAPTURE_OFFSET.
  assign cyc_rel     = cyc_q - OFFSET;
  assign grp         = cyc_rel[7:2];
  assign box_sel     = 3'd3 - grp[2:0];
  assign capture_hit = ((state_q == WAIT) && (cyc_q == OFFSET)) ||
                       ((state_q == GEN)  && (cyc_rel[1:0] == 2'b00));

  serpent_sbox_slice u_slice (
    .group_in (pre_roundKeys),
    .box_sel  (box_sel),
    .key_out  (slice_key)
  );

  // NOTE: every _d gets a default first, so no path through this block can infer a latch.
  always_comb begin
    state_d        = state_q;
    cyc_d          = cyc_q;
    keys_written_d = keys_written_q;
    done_d         = done_q;
    rk_valid_d     = 1'b0;
    rk_data_d      = rk_data_q;
    rk_num_d       = rk_num_q;

    if (sched_start) begin
      // Restart wins over any capture in flight; that capture is simply dropped.
      state_d        = WAIT;
      cyc_d          = 8'd1;
      keys_written_d = '0;
      done_d         = 1'b0;
    end else begin
      case (state_q)
        WAIT, GEN: begin
          if (cyc_q != 8'hFF) cyc_d = cyc_q + 8'd1;
          if (capture_hit) begin
            rk_valid_d     = 1'b1;
            rk_data_d      = slice_key;
            rk_num_d       = grp;
            keys_written_d = keys_written_q + 6'd1;
            if (grp == LAST_GRP) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = GEN;
            end
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == WAIT) || (state_d == GEN);
  end

  // Key file read with write-first bypass of the key being written this cycle.
  always_comb begin
    rk_out_valid_d = (rk_idx < keys_written_q);
    if (rk_idx >= NUM_K6) begin
      rk_out_d = '0;
    end else if (rk_valid_q && (rk_idx == rk_num_q)) begin
      rk_out_d = rk_data_q;
    end else begin
      rk_out_d = key_file[rk_idx];
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cyc_q          <= '0;
      keys_written_q <= '0;
      rk_valid_q     <= 1'b0;
      rk_data_q      <= '0;
      rk_num_q       <= '0;
      rk_out_q       <= '0;
      rk_out_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cyc_q          <= cyc_d;
      keys_written_q <= keys_written_d;
      rk_valid_q     <= rk_valid_d;
      rk_data_q      <= rk_data_d;
      rk_num_q       <= rk_num_d;
      rk_out_q       <= rk_out_d;
      rk_out_valid_q <= rk_out_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  // NOTE: the key file is deliberately not reset; rk_out_valid masks stale entries so it maps to plain RAM.
  always_ff @(posedge clk) begin
    if (rk_valid_q) key_file[rk_num_q] <= rk_data_q;
  end

  assign rk_valid     = rk_valid_q;
  assign rk_data      = rk_data_q;
  assign rk_num       = rk_num_q;
  assign rk_out       = rk_out_q;
  assign rk_out_valid = rk_out_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_serpent_roundkey_gen.sv
`timescale 1ns/1ps
// Bench for serpent_roundkey_gen: a cycles-since-start reference model checked every
// cycle, plus directed scenarios with hand-computed keys and timing.
module tb_serpent_roundkey_gen;

  localparam int NK  = 33;
  localparam int OFF = 8;

  localparam int SB [8][16] = '{
    '{3, 8, 15, 1, 10, 6, 5, 11, 14, 13, 4, 2, 7, 0, 9, 12},
    '{15, 12, 2, 7, 9, 0, 5, 10, 1, 11, 14, 8, 6, 13, 3, 4},
    '{8, 6, 7, 9, 3, 12, 10, 15, 13, 1, 14, 4, 0, 11, 5, 2},
    '{0, 15, 11, 8, 12, 9, 6, 3, 13, 1, 2, 4, 10, 7, 5, 14},
    '{1, 15, 8, 3, 12, 0, 11, 6, 2, 5, 4, 10, 9, 14, 7, 13},
    '{15, 5, 2, 11, 4, 10, 9, 12, 0, 3, 14, 8, 13, 6, 7, 1},
    '{7, 2, 12, 5, 8, 4, 6, 11, 14, 9, 1, 15, 13, 3, 10, 0},
    '{1, 13, 15, 0, 14, 8, 2, 11, 7, 4, 12, 10, 9, 3, 5, 6}
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         sched_start;
  logic [127:0] pre_roundKeys;
  logic         rk_valid;
  logic [127:0] rk_data;
  logic [5:0]   rk_num;
  logic [5:0]   rk_idx;
  logic [127:0] rk_out;
  logic         rk_out_valid;
  logic         busy;
  logic         done;

  serpent_roundkey_gen #(
    .NUM_KEYS       (NK),
    .CAPTURE_OFFSET (OFF),
    .KEY_W          (128)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sched_start   (sched_start),
    .pre_roundKeys (pre_roundKeys),
    .rk_valid      (rk_valid),
    .rk_data       (rk_data),
    .rk_num        (rk_num),
    .rk_idx        (rk_idx),
    .rk_out        (rk_out),
    .rk_out_valid  (rk_out_valid),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round key of group g straight from the bitslice definition.
  function automatic logic [127:0] model_key(input logic [127:0] w, input int g);
    logic [127:0] r;
    logic [3:0]   nib;
    logic [3:0]   o;
    int           box;
    box = (3 - g) & 7;
    r   = '0;
    for (int j = 0; j < 32; j++) begin
      nib = {w[96+j], w[64+j], w[32+j], w[j]};
      o   = 4'(SB[box][nib]);
      for (int b = 0; b < 4; b++) r[32*b+j] = o[b];
    end
    return r;
  endfunction

  // Reference model: counts edges since the accepted sched_start.
  int           edge_no = 0;
  int           start_edge = 0;
  int           run_id = 0;
  bit           m_active = 1'b0;
  bit           m_done = 1'b0;
  int           m_kw = 0;
  bit           e_valid = 1'b0;
  logic [127:0] e_data = '0;
  int           e_num = 0;
  bit           e_out_chk = 1'b0;
  bit           e_out_valid = 1'b0;
  logic [127:0] e_out = '0;
  logic [127:0] m_file [NK];
  int           mk, mg;

  always @(posedge clk) begin
    edge_no++;
    e_out_valid = (int'(rk_idx) < m_kw);
    e_out_chk   = e_out_valid || (int'(rk_idx) >= NK);
    if (int'(rk_idx) >= NK) e_out = '0;
    else                    e_out = m_file[rk_idx];

    if (rst) begin
      m_active = 1'b0; m_done = 1'b0; m_kw = 0;
      e_valid = 1'b0; e_data = '0; e_num = 0;
      e_out_chk = 1'b1; e_out = '0; e_out_valid = 1'b0;
      run_id++;
    end else if (sched_start) begin
      m_active = 1'b1; m_done = 1'b0; m_kw = 0;
      start_edge = edge_no; e_valid = 1'b0;
      run_id++;
    end else begin
      e_valid = 1'b0;
      if (m_active) begin
        mk = edge_no - start_edge;
        if (mk >= OFF && ((mk - OFF) % 4) == 0) begin
          mg = (mk - OFF) / 4;
          e_valid = 1'b1;
          e_data  = model_key(pre_roundKeys, mg);
          e_num   = mg;
          m_file[mg] = e_data;
          m_kw    = mg + 1;
          if (mg == NK - 1) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end
        end
      end
    end
  end

  // Compare process plus per-run bookkeeping for the directed checks.
  int           run_seen = 0;
  int           pulses = 0;
  int           first_cyc = -1;
  int           first_num = -1;
  int           done_cyc = -1;
  int           cur;
  logic [127:0] cap [NK];

  always @(negedge clk) begin
    if (edge_no > 0) begin
      if (run_id != run_seen) begin
        run_seen = run_id; pulses = 0; first_cyc = -1; first_num = -1; done_cyc = -1;
      end
      cur = edge_no - start_edge + 1;
      check("rk_valid", 128'(rk_valid), 128'(e_valid));
      if (e_valid) begin
        check("rk_data", rk_data, e_data);
        check("rk_num", 128'(rk_num), 128'(e_num));
      end
      check("busy", 128'(busy), 128'(m_active));
      check("done", 128'(done), 128'(m_done));
      check("rk_out_valid", 128'(rk_out_valid), 128'(e_out_valid));
      if (e_out_chk) check("rk_out", rk_out, e_out);
      if (rk_valid === 1'b1) begin
        pulses++;
        if (first_cyc < 0) begin
          first_cyc = cur;
          first_num = int'(rk_num);
        end
        if (int'(rk_num) < NK) cap[rk_num] = rk_data;
      end
      if (done === 1'b1 && done_cyc < 0) done_cyc = cur;
    end
  end

  // Stimulus helpers; win_at(pat, k) is the window sampled k edges after the start edge.
  int drv_k   = 0;
  int drv_pat = 0;
  bit sweep   = 1'b0;

  function automatic logic [127:0] win_at(input int pat, input int k);
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    case (pat)
      0: w = '0;
      1: begin
        if (k == 8)       w = '1;
        else if (k == 12) w = 128'h00000000_00000000_80000000_00000000;
      end
      2: if (k == 8) w = 128'h00000000_00000000_00000000_00000001;
      default: ;
    endcase
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic next_cycle();
    step();
    drv_k++;
    pre_roundKeys = win_at(drv_pat, drv_k);
    if (sweep) rk_idx = 6'((drv_k * 7) % 41);
  endtask

  task automatic step_n(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic do_start(input int pat);
    sched_start   = 1'b1;
    pre_roundKeys = win_at(pat, 0);
    step();
    sched_start   = 1'b0;
    drv_pat       = pat;
    drv_k         = 1;
    pre_roundKeys = win_at(pat, 1);
    if (sweep) rk_idx = 6'(7 % 41);
  endtask

  initial begin
    rst = 1'b1; sched_start = 1'b0; pre_roundKeys = '0; rk_idx = 6'd40;
    repeat (3) step();
    check("reset_rk_valid", 128'(rk_valid), 128'(0));
    check("reset_rk_data", rk_data, '0);
    check("reset_rk_num", 128'(rk_num), 128'(0));
    check("reset_rk_out", rk_out, '0);
    check("reset_rk_out_valid", 128'(rk_out_valid), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    rst = 1'b0;
    step();

    // Hand-computed pins for the model itself.
    check("model_s3_ones", model_key('1, 0), 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000);
    check("model_s3_bit0", model_key(128'h1, 0), 128'h00000001_00000001_00000001_00000001);
    check("model_s2_bit31", model_key(128'h00000000_00000000_80000000_00000000, 1),
          128'h7FFFFFFF_80000000_80000000_80000000);

    // Zero window: keys depend only on Sb[0].
    sweep = 1'b1;
    do_start(0);
    step_n(139);
    check("zero_pulses", 128'(pulses), 128'(NK));
    check("zero_first_cycle", 128'(first_cyc), 128'(9));
    check("zero_done_cycle", 128'(done_cyc), 128'(137));
    check("zero_k0", cap[0], '0);
    check("zero_k1", cap[1], 128'hFFFFFFFF_00000000_00000000_00000000);
    check("zero_done_held", 128'(done), 128'(1));

    // Directed groups 0/1, bypass on key 5, then key-file readback.
    sweep  = 1'b0;
    rk_idx = 6'd5;
    do_start(1);
    step_n(28);
    check("byp_k5_valid", 128'(rk_valid), 128'(1));
    check("byp_k5_num", 128'(rk_num), 128'(5));
    check("byp_not_yet_valid", 128'(rk_out_valid), 128'(0));
    step_n(1);
    check("byp_rk_out", rk_out, m_file[5]);
    check("byp_rk_out_valid", 128'(rk_out_valid), 128'(1));
    step_n(120);
    check("ones_k0", cap[0], 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000);
    check("bit31_k1", cap[1], 128'h7FFFFFFF_80000000_80000000_80000000);
    check("run2_pulses", 128'(pulses), 128'(NK));
    check("run2_done", 128'(done), 128'(1));
    for (int i = 0; i < NK; i++) begin
      rk_idx = 6'(i);
      step();
      check($sformatf("readback_%0d", i), rk_out, cap[i]);
      check($sformatf("readback_valid_%0d", i), 128'(rk_out_valid), 128'(1));
    end
    rk_idx = 6'd40;
    step();
    check("read_oob_data", rk_out, '0);
    check("read_oob_valid", 128'(rk_out_valid), 128'(0));

    // Restart at cycle 50, then again at cycle 12 where a capture is in flight.
    sweep = 1'b1;
    do_start(2);
    step_n(49);
    do_start(1);
    check("restart_done_clear", 128'(done), 128'(0));
    check("restart_busy", 128'(busy), 128'(1));
    step_n(11);
    sweep  = 1'b0;
    rk_idx = 6'd0;
    do_start(2);
    step_n(1);
    check("restart_kw_cleared", 128'(rk_out_valid), 128'(0));
    sweep = 1'b1;
    step_n(139);
    check("restart_pulses", 128'(pulses), 128'(NK));
    check("restart_first_cycle", 128'(first_cyc), 128'(9));
    check("restart_first_num", 128'(first_num), 128'(0));
    check("restart_k0", cap[0], 128'h00000001_00000001_00000001_00000001);
    check("restart_done", 128'(done), 128'(1));

    // Synchronous reset in the middle of generation (cycle 30).
    do_start(1);
    step_n(29);
    sweep = 1'b0;
    rst   = 1'b1;
    step();
    rst   = 1'b0;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_rk_valid", 128'(rk_valid), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    for (int i = 0; i <= 40; i++) begin
      rk_idx = 6'(i);
      step();
      check($sformatf("rst_read_valid_%0d", i), 128'(rk_out_valid), 128'(0));
    end
    repeat (150) step();
    check("rst_no_pulses", 128'(pulses), 128'(0));
    check("rst_idle_busy", 128'(busy), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
